parking_log_reader: RTL and testbench

//  Read-side client of the 8-entry x 4-bit occupancy log RAM. On start, sweeps every
//  RAM address in order, drives rdaddress, captures q and streams each (addr, data)

---
 rtl/parking_pkg.sv | 14 +
 rtl/log_stats.sv | 39 +++
 rtl/parking_log_reader.sv | 100 ++++++++++
 tb/tb_parking_log_reader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the occupancy log RAM and its read-side client.
package parking_pkg;

  localparam int unsigned LOG_ADDR_W = 3;
  localparam int unsigned LOG_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    PRESENT,
    DONE
  } log_rd_state_t;

endpackage

// File: rtl/log_stats.sv
// Running sum and peak tracker over the entries of one log sweep.
// A new peak must be strictly greater, so ties keep the lowest address.
module log_stats
  import parking_pkg::*;
#(
  parameter int unsigned ADDR_W = LOG_ADDR_W,
  parameter int unsigned DATA_W = LOG_DATA_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     en,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W+ADDR_W-1:0] total,
  output logic [DATA_W-1:0]        peak,
  output logic [ADDR_W-1:0]        peak_addr
);

  // Clear on sweep start, accumulate one entry per enabled cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      total     <= '0;
      peak      <= '0;
      peak_addr <= '0;
    end else if (clear) begin
      total     <= '0;
      peak      <= '0;
      peak_addr <= '0;
    end else if (en) begin
      total <= total + (DATA_W+ADDR_W)'(din);
      if (din > peak) begin
        peak      <= din;
        peak_addr <= addr;
      end
    end
  end

endmodule

// File: rtl/parking_log_reader.sv
// Sweeps the occupancy log RAM, streams each (addr, data) entry over a
// valid/ready handshake and keeps total/peak statistics for the last sweep.
module parking_log_reader
  import parking_pkg::*;
#(
  parameter int unsigned ADDR_W = LOG_ADDR_W,
  parameter int unsigned DATA_W = LOG_DATA_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  output logic [ADDR_W-1:0]        rdaddress,
  input  logic [DATA_W-1:0]        q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W+ADDR_W-1:0] total,
  output logic [DATA_W-1:0]        peak,
  output logic [ADDR_W-1:0]        peak_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  log_rd_state_t     state;
  logic [ADDR_W-1:0] ptr;
  logic              stats_clear;
  logic              stats_en;

  // ptr only moves on entry to READ, so it doubles as the registered
  // RAM address and naturally holds its value outside READ.
  assign rdaddress   = ptr;
  assign stats_clear = (state == IDLE) && start;
  assign stats_en    = (state == READ);

  // Sweep sequencer with registered handshake and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        READ: begin
          out_data  <= q;
          out_addr  <= ptr;
          out_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (ptr == LAST_ADDR) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= READ;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  log_stats #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_stats (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (stats_clear),
    .en        (stats_en),
    .addr      (ptr),
    .din       (q),
    .total     (total),
    .peak      (peak),
    .peak_addr (peak_addr)
  );

endmodule

// File: tb/tb_parking_log_reader.sv
// Scoreboard bench for parking_log_reader with a behavioural 8x4 RAM.
module tb_parking_log_reader;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [2:0] rdaddress;
  logic [3:0] q;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_addr;
  logic [3:0] out_data;
  logic       busy;
  logic       done;
  logic [6:0] total;
  logic [3:0] peak;
  logic [2:0] peak_addr;

  logic [3:0] ram [8];
  logic [3:0] mdl [8];

  typedef struct {
    logic [2:0] a;
    logic [3:0] d;
  } ent_t;
  ent_t sb[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int exp_total, exp_peak, exp_paddr;

  assign q = ram[rdaddress];

  parking_log_reader #(
    .ADDR_W(3),
    .DATA_W(4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .rdaddress (rdaddress),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .total     (total),
    .peak      (peak),
    .peak_addr (peak_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Handshake monitor: every accepted entry must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_extra_entry", {29'd0, out_addr}, 32'd8);
      end else begin
        ent_t e;
        e = sb.pop_front();
        check("sb_addr", {29'd0, out_addr}, {29'd0, e.a});
        check("sb_data", {28'd0, out_data}, {28'd0, e.d});
      end
    end
    if (reset_n && done) done_cnt++;
  end

  // Queue the first n entries of mdl and derive expected stats over all of mdl.
  task automatic push_sweep(input int n);
    ent_t e;
    exp_total = 0;
    exp_peak  = 0;
    exp_paddr = 0;
    for (int i = 0; i < 8; i++) begin
      exp_total += mdl[i];
      if (int'(mdl[i]) > exp_peak) begin
        exp_peak  = mdl[i];
        exp_paddr = i;
      end
      if (i < n) begin
        e.a = 3'(i);
        e.d = mdl[i];
        sb.push_back(e);
      end
    end
  endtask

  task automatic do_start(output int n);
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    n = cyc;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (done) begin
        at = cyc;
        return;
      end
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_present(input int a);
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      if (out_valid && (int'(out_addr) == a)) return;
    end
    check("present_timeout", {29'd0, out_addr}, a);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_addr"},  {29'd0, out_addr}, 32'd0);
    check({tag, "_data"},  {28'd0, out_data}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_total"}, {25'd0, total}, 32'd0);
    check({tag, "_peak"},  {28'd0, peak}, 32'd0);
    check({tag, "_paddr"}, {29'd0, peak_addr}, 32'd0);
    check({tag, "_rdaddr"}, {29'd0, rdaddress}, 32'd0);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_total"}, {25'd0, total}, exp_total);
    check({tag, "_peak"},  {28'd0, peak}, exp_peak);
    check({tag, "_paddr"}, {29'd0, peak_addr}, exp_paddr);
    check({tag, "_sb_left"}, sb.size(), 32'd0);
  endtask

  task automatic full_sweep(input string tag);
    int n, at, base;
    base = done_cnt;
    push_sweep(8);
    do_start(n);
    wait_done(at);
    check({tag, "_done_cyc"}, at, n + 16);
    repeat (4) @(posedge clock);
    #1;
    check({tag, "_done_cnt"}, done_cnt - base, 32'd1);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check_stats(tag);
  endtask

  initial begin
    int n, at, base;
    reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) ram[i] = '0;
    #1 check_zero("reset");
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // 1: reference pattern, latency and stats
    mdl = '{4'd3, 4'd0, 4'd7, 4'd7, 4'd1, 4'd15, 4'd2, 4'd4};
    ram = mdl;
    base = done_cnt;
    push_sweep(8);
    do_start(n);
    check("t1_busy_after_start", {31'd0, busy}, 32'd1);
    @(negedge clock);
    check("t1_valid_n1", {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    check("t1_valid_n2", {31'd0, out_valid}, 32'd1);
    wait_done(at);
    check("t1_done_cyc", at, n + 16);
    check("t1_busy_in_done", {31'd0, busy}, 32'd0);
    repeat (4) @(posedge clock);
    #1;
    check("t1_done_cnt", done_cnt - base, 32'd1);
    check("t1_total_const", {25'd0, total}, 32'd39);
    check("t1_peak_const", {28'd0, peak}, 32'd15);
    check("t1_paddr_const", {29'd0, peak_addr}, 32'd5);
    check_stats("t1");

    // 2: ties and all-zero
    for (int i = 0; i < 8; i++) mdl[i] = 4'd9;
    ram = mdl;
    full_sweep("t2_nines");
    check("t2_total_const", {25'd0, total}, 32'd72);
    for (int i = 0; i < 8; i++) mdl[i] = 4'd0;
    ram = mdl;
    full_sweep("t2_zero");

    // 3: backpressure at addr 3
    mdl = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    ram = mdl;
    base = done_cnt;
    push_sweep(8);
    do_start(n);
    wait_present(3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t3_hold_addr", {29'd0, out_addr}, 32'd3);
      check("t3_hold_data", {28'd0, out_data}, {28'd0, mdl[3]});
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    wait_done(at);
    repeat (2) @(posedge clock);
    #1;
    check("t3_done_cnt", done_cnt - base, 32'd1);
    check_stats("t3");

    // 4: full-scale sum; start held through busy and DONE is ignored
    for (int i = 0; i < 8; i++) mdl[i] = 4'd15;
    ram = mdl;
    base = done_cnt;
    push_sweep(8);
    do_start(n);
    @(posedge clock);
    #1 start = 1'b1;
    wait_done(at);
    start = 1'b0;
    check("t4_done_cyc", at, n + 16);
    repeat (20) @(posedge clock);
    #1;
    check("t4_done_cnt", done_cnt - base, 32'd1);
    check("t4_busy_idle", {31'd0, busy}, 32'd0);
    check("t4_total_const", {25'd0, total}, 32'h78);
    check_stats("t4");

    // 5: reset mid-sweep while presenting addr 4
    mdl = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    ram = mdl;
    base = done_cnt;
    push_sweep(4);
    do_start(n);
    wait_present(4);
    reset_n = 1'b0;
    #1 check_zero("t5_abort");
    repeat (3) @(posedge clock);
    #1;
    check("t5_no_done", done_cnt - base, 32'd0);
    check("t5_sb_drained", sb.size(), 32'd0);
    reset_n = 1'b1;
    full_sweep("t5_clean");

    // 6: concurrent write to addr 6 while addr 2 is presented
    mdl = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd1, 4'd3, 4'd5};
    ram = mdl;
    mdl[6] = 4'd12;
    base = done_cnt;
    push_sweep(8);
    do_start(n);
    wait_present(2);
    ram[6] = 4'd12;
    wait_done(at);
    repeat (2) @(posedge clock);
    #1;
    check("t6_done_cnt", done_cnt - base, 32'd1);
    check("t6_total_const", {25'd0, total}, 32'd48);
    check_stats("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d want=0", cyc);
    $fatal(1, "global timeout");
  end

endmodule
